// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave that drives six active-low 7-segment digits from a 24-bit hex value.
// It supports per-digit blanking and blinking, plus a raw-segment override. Each digit output is registered.

module hex_display_digit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       blink,
  input  logic       blink_phase,
  input  logic       raw_en,
  input  logic [6:0] raw,
  output logic [6:0] seg
);

  logic [6:0] dec;
  logic [6:0] seg_nxt;

  always_comb begin
    dec = 7'h7F;
    unique case (nibble)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
    endcase
  end

  // Blanking beats blinking, and blinking beats the raw/decoded source.
  always_comb begin
    seg_nxt = dec;
    if (blank)                    seg_nxt = 7'h7F;
    else if (blink && blink_phase) seg_nxt = 7'h7F;
    else if (raw_en)              seg_nxt = raw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seg <= 7'h7F;
    else          seg <= seg_nxt;
  end

endmodule

module hex_display_ctrl #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam int NUM_DIGITS = 6;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [23:0]                      value;
  logic [NUM_DIGITS-1:0]            blank_mask;
  logic [NUM_DIGITS-1:0]            blink_mask;
  logic                             raw_en;
  logic [NUM_DIGITS-1:0][6:0]       raw;
  logic [CW-1:0]                    cnt;
  logic                             blink_phase;
  logic [NUM_DIGITS-1:0][6:0]       seg;
  logic                             wr;

  assign wr = chipselect && !write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value      <= '0;
      blank_mask <= '1;
      blink_mask <= '0;
      raw_en     <= 1'b0;
      raw        <= {NUM_DIGITS{7'h7F}};
    end else if (wr) begin
      unique case (address)
        2'd0: value <= writedata[23:0];
        2'd1: begin
          blank_mask <= writedata[5:0];
          blink_mask <= writedata[11:6];
          raw_en     <= writedata[12];
        end
        2'd2: begin
          raw[0] <= writedata[6:0];
          raw[1] <= writedata[13:7];
          raw[2] <= writedata[20:14];
          raw[3] <= writedata[27:21];
        end
        2'd3: begin
          raw[4] <= writedata[6:0];
          raw[5] <= writedata[13:7];
        end
      endcase
    end
  end

  // Free-running blink timer; CTRL writes never disturb it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      blink_phase <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt         <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata = {8'b0, value};
      2'd1: readdata = {blink_phase, 18'b0, raw_en, blink_mask, blank_mask};
      2'd2: readdata = {4'b0, raw[3], raw[2], raw[1], raw[0]};
      2'd3: readdata = {18'b0, raw[5], raw[4]};
    endcase
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_display_digit u_digit (
      .clk         (clk),
      .reset_n     (reset_n),
      .nibble      (value[4*g +: 4]),
      .blank       (blank_mask[g]),
      .blink       (blink_mask[g]),
      .blink_phase (blink_phase),
      .raw_en      (raw_en),
      .raw         (raw[g]),
      .seg         (seg[g])
    );
  end

  assign hex0 = seg[0];
  assign hex1 = seg[1];
  assign hex2 = seg[2];
  assign hex3 = seg[3];
  assign hex4 = seg[4];
  assign hex5 = seg[5];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl with BLINK_DIV=4: stimulus queues expectations,
// and a negedge monitor pops them and compares them against the DUT.

module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [6:0]  hx [6];

  hex_display_ctrl #(.BLINK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  assign hx[0] = hex0;
  assign hx[1] = hex1;
  assign hx[2] = hex2;
  assign hx[3] = hex3;
  assign hx[4] = hex4;
  assign hx[5] = hex5;

  typedef struct {
    int          sig;   // 0..5 = hexN, 6 = readdata
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   req_cnt = 0;
  int   ack_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  // Rising edges seen since reset release; mirrors the blink timer.
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic logic ph(input int c);
    return ((c / 4) % 2) == 1;
  endfunction

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (req_cnt != ack_cnt) begin
        while (sb.size() > 0) begin
          e   = sb.pop_front();
          act = (e.sig < 6) ? {25'b0, hx[e.sig]} : readdata;
          tests++;
          if (act !== e.exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
          end
        end
        ack_cnt = req_cnt;
      end
    end
  end

  task automatic push(input int sig, input logic [31:0] exp, input string name);
    exp_t e;
    e.sig = sig; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic push_hex(input logic [6:0] h0, h1, h2, h3, h4, h5, input string name);
    push(0, {25'b0, h0}, {name, "_hex0"});
    push(1, {25'b0, h1}, {name, "_hex1"});
    push(2, {25'b0, h2}, {name, "_hex2"});
    push(3, {25'b0, h3}, {name, "_hex3"});
    push(4, {25'b0, h4}, {name, "_hex4"});
    push(5, {25'b0, h5}, {name, "_hex5"});
  endtask

  task automatic check();
    int t;
    req_cnt++;
    t = 0;
    while (ack_cnt != req_cnt && t < 100) begin #1; t++; end
    if (ack_cnt != req_cnt) begin
      $display("FAIL monitor_timeout: got no sample expected sample within 100 time units");
      $fatal(1);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    push(6, exp, name);
    check();
  endtask

  task automatic wr_now(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_now(a, d);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end

  initial begin : stim
    logic [6:0] d;
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    push_hex(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, "por");
    check();
    rd(2'd1, 32'h0000_003F, "por_ctrl");
    @(negedge clk);
    reset_n = 1'b1;

    // Decode of 0x123456
    wr(2'd0, 32'h0012_3456);
    wr(2'd1, 32'h0);
    next_cycle();
    push_hex(7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, "dec123456");
    check();
    rd(2'd0, 32'h0012_3456, "value_rb");

    // Full decode table sweep
    for (int i = 0; i < 16; i++) begin
      wr(2'd0, 32'h0011_1111 * i);
      next_cycle();
      d = dec_tbl[i];
      push_hex(d, d, d, d, d, d, $sformatf("sweep%0d", i));
      check();
    end

    // Blink on digit 0
    wr(2'd0, 32'h0000_0008);
    wr(2'd1, 32'h0000_0040);
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      push_hex(ph(cyc - 1) ? 7'h7F : 7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, "blink");
      address = 2'd1;
      push(6, {ph(cyc), 31'h0000_0040}, "blink_ctrl");
      check();
    end

    // Priority: blank over blink over raw
    wr(2'd2, 32'h0000_1F80);
    wr(2'd1, 32'h0000_1082);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      push_hex(7'h00, 7'h7F, 7'h00, 7'h00, 7'h7F, 7'h7F, "prio_blank");
      check();
    end
    wr(2'd1, 32'h0000_1080);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      push_hex(7'h00, ph(cyc - 1) ? 7'h7F : 7'h3F, 7'h00, 7'h00, 7'h7F, 7'h7F, "prio_blink");
      check();
    end

    // Raw override and ignored writes
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h0000_3FFF);
    wr(2'd1, 32'h0000_1000);
    next_cycle();
    push_hex(7'h00, 7'h00, 7'h00, 7'h00, 7'h7F, 7'h7F, "raw");
    check();
    rd(2'd3, 32'h0000_3FFF, "rawhi_rb");
    rd(2'd2, 32'h0, "rawlo_rb");
    @(negedge clk);
    address = 2'd1; writedata = 32'h0000_003F; chipselect = 1'b0; write_n = 1'b0;
    @(negedge clk);
    address = 2'd0; writedata = 32'h00AB_CDEF;
    @(negedge clk);
    write_n = 1'b1;
    next_cycle();
    push_hex(7'h00, 7'h00, 7'h00, 7'h00, 7'h7F, 7'h7F, "nocs");
    check();
    rd(2'd0, 32'h0000_0008, "nocs_value");
    address = 2'd1;
    push(6, {ph(cyc), 31'h0000_1000}, "nocs_ctrl");
    check();

    // CTRL write landing on the wrap edge that raises blink_phase
    @(negedge clk);
    while ((cyc + 1) % 8 != 4) @(negedge clk);
    wr_now(2'd1, 32'h0000_1040);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      push(0, {25'b0, ph(cyc - 1) ? 7'h7F : 7'h00}, "wrap_hex0");
      push(1, {25'b0, 7'h00}, "wrap_hex1");
      check();
    end

    // Mid-run asynchronous reset
    @(posedge clk); #1;
    reset_n = 1'b0;
    push_hex(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, "async_rst");
    check();
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, 32'h0, "rst_value");
    address = 2'd1;
    push(6, {ph(cyc), 31'h0000_003F}, "rst_ctrl");
    check();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      push_hex(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, "post_rst");
      check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Avalon-MM slave that drives six active-low 7-segment digits (HEX0..HEX5) from a single 24-bit hex value written by the CPU. The block decodes the value into segment patterns in hardware and supports per-digit blanking, per-digit blinking and a raw-segment override. It sits on the same Avalon bus as the other wasca PIO slaves, and its digit outputs connect directly to the board's HEX pins.

Parameters:
BLINK_DIV, 25000000, blink half-period in clk cycles (0.5 s at 50 MHz); legal range >= 2.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational, zero wait states
hex0..hex5  out  7 each  segment outputs, active-low, bit0=a .. bit6=g

Behaviour:
- Reset is reset_n, asynchronous and active-low; the clock is clk. All state resets asynchronously.
- Reset values:
  - value = 0
  - blank_mask = 6'h3F (all digits dark)
  - blink_mask = 0
  - raw_en = 0
  - raw[0..5] = 7'h7F
  - blink counter = 0, blink_phase = 0
  - hex0..hex5 = 7'h7F
- A write occurs when chipselect=1 and write_n=0. Any write with chipselect=0 is ignored.
- Register map (readdata returns 0 in unused bits):
  - addr 0 VALUE: [23:0] value, RW. Digit n shows nibble value[4n+3:4n].
  - addr 1 CTRL:
    - [5:0] blank_mask, RW
    - [11:6] blink_mask, RW
    - [12] raw_en, RW
    - [31] blink_phase, RO (write ignored)
  - addr 2 RAW_LO: [6:0] raw0, [13:7] raw1, [20:14] raw2, [27:21] raw3, RW.
  - addr 3 RAW_HI: [6:0] raw4, [13:7] raw5, RW.
- Decode table (active-low, hex value -> segments):
  - 0 -> 40, 1 -> 79, 2 -> 24, 3 -> 30
  - 4 -> 19, 5 -> 12, 6 -> 02, 7 -> 78
  - 8 -> 00, 9 -> 10, A -> 08, b -> 03
  - C -> 46, d -> 21, E -> 06, F -> 0E
- Blink timer:
  - Free-running counter from 0 to BLINK_DIV-1; it wraps to 0 and toggles blink_phase on the wrap cycle.
  - The timer runs regardless of the mask settings.
  - With BLINK_DIV=N, blink_phase toggles every N cycles.
- Per-digit output selection, with this priority:
  1. blank_mask[n] = 1 -> 7F
  2. blink_mask[n] = 1 and blink_phase = 1 -> 7F
  3. raw_en = 1 -> raw[n]
  4. otherwise -> decode(nibble n)
- Outputs are registered. A register write at edge k is visible on hex outputs after edge k+1 (one cycle of latency). A blink_phase toggle takes effect on the hex outputs with the same one-cycle latency.
- Simultaneous events: a CTRL write on the same edge as a blink wrap is legal. The next output update uses both the new masks and the new phase. A CTRL write never resets the blink counter.
- Reset asserted mid-operation forces all outputs to 7F immediately (asynchronously). After release, the display stays dark until software clears blank_mask.
- No byte enables: every write updates the full register.

Test Plan:
- Reset: assert reset_n=0 mid-run -> hex0..5 = 7F immediately; after release, CTRL reads 0x0000003F, VALUE reads 0, and the outputs stay 7F.
- Decode: write VALUE=0x123456 then CTRL=0 -> one cycle later hex0=02, hex1=12, hex2=19, hex3=30, hex4=24, hex5=79; VALUE reads back 0x00123456.
- Full table: sweep VALUE=0x000000..0xFFFFFF in steps of 0x111111 -> every digit matches the decode table for nibbles 0..F.
- Blink (BLINK_DIV=4): with CTRL blink_mask=0x01 and VALUE=0x000008 -> hex0 alternates 00 / 7F every 4 cycles, hex1..5 stay 40, and CTRL[31] tracks the phase.
- Priority: set blank_mask=0x02, blink_mask=0x02, raw_en=1, RAW_LO raw1=0x3F -> hex1 = 7F in both blink phases. Then clear blank_mask -> hex1 alternates 3F / 7F.
- Raw and no-op writes: raw_en=1, RAW_LO=0x0000000, RAW_HI=0x3FFF -> hex0..3 = 00 and hex4..5 = 7F. A write with chipselect=0 changes nothing, and a CTRL write on the wrap cycle applies the new mask together with the new phase.
